coder_speed: RTL
================

CODER_SPEED -- requirements
Module: coder_speed

Interface
REQ-001 SHALL have parameter U_DLY, default 1, meaning register assignment delay (ns) for simulation.
REQ-002 SHALL have parameter CLK_DIV, default 80, meaning clk cycles per 1 us tick.
REQ-003 SHALL have parameter WIN_US, default 1000, meaning us ticks per measurement window.
REQ-004 SHALL have parameter STALL_WIN, default 8, meaning consecutive zero-delta windows before stall.
REQ-005 SHALL have port clk, input, 1, the single system clock.
REQ-006 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port en, input, 1, meaning measurement enable.
REQ-008 SHALL have port pco, input, 16, meaning encoder position count from the upstream quadrature counter, in clk domain.
REQ-009 SHALL have port speed, output, 16, meaning signed two's-complement averaged counts per window.
REQ-010 SHALL have port speed_vld, output, 1, meaning one-cycle strobe when speed updates.
REQ-011 SHALL have port dir, output, 1: 1 = speed negative (decrementing count), 0 otherwise.
REQ-012 SHALL have port stall, output, 1, meaning no position change for STALL_WIN windows.

Function
REQ-013 SHALL generate tick for one cycle when a 0..CLK_DIV-1 cycle counter equals CLK_DIV-1; the counter free-runs in all states.
REQ-014 SHALL count ticks in win_cnt 0..WIN_US-1; window end (WE) is the cycle where tick=1 and win_cnt=WIN_US-1; win_cnt wraps to 0 at WE.
REQ-015 SHALL implement states IDLE, PRIME, RUN.
REQ-016 SHALL hold IDLE while en=0, with win_cnt=0, history cleared, zero_cnt=0, and outputs speed=0, dir=0, stall=0, speed_vld=0.
REQ-017 SHALL move IDLE->PRIME on the cycle en=1 is first sampled; win_cnt starts from 0.
REQ-018 SHALL in PRIME, at WE, load pos_prev<=pco, emit no strobe, and move to RUN.
REQ-019 SHALL in RUN, at each WE: delta<=pco-pos_prev (16-bit modulo, read as signed), pos_prev<=pco, shift delta into a 4-entry history (oldest dropped).
REQ-020 SHALL compute speed as an 18-bit signed sum of the 4 history entries, arithmetic-shifted right 2 (floor), truncated to 16 bits.
REQ-021 SHALL zero all history entries on PRIME entry, so the first three RUN outputs average with zeros.
REQ-022 SHALL have latency: history updated at WE+1, speed/dir/speed_vld registered at WE+2; speed_vld high exactly one cycle per RUN window.
REQ-023 SHALL hold speed and dir between strobes.
REQ-024 SHALL count zero_cnt on delta=0 (saturating at STALL_WIN) and clear it on delta!=0; stall=1 while zero_cnt=STALL_WIN, updated with speed_vld.
REQ-025 SHALL wrap-around: pco crossing 0xFFFF->0x0000 yields correct signed delta provided |true delta|<32768 per window.
REQ-026 SHALL on en deassert in any state return to IDLE next cycle, abandon the pending window (no strobe), and apply the REQ-016 clears.

Reset
REQ-027 SHALL on rst_n=0 immediately set state=IDLE, all counters, pos_prev, history, zero_cnt=0, speed=0, speed_vld=0, dir=0, stall=0.
REQ-028 SHALL after rst_n release, begin the tick counter from 0 on the first clk edge.

Verification (CLK_DIV=4, WIN_US=10: window = 40 cycles)
REQ-029 SHALL cover: en=1, pco constant 0x1000 -> first strobe 2 cycles after second WE, speed=0; after 8 RUN windows stall=1.
REQ-030 SHALL cover: pco +20 per window steady -> speed 5,10,15,20,20...; dir=0; stall=0.
REQ-031 SHALL cover: pco -8 per window from 0x0004 (wraps through 0xFFFC) -> speed -2,-4,-6,-8 (0xFFF8); dir=1.
REQ-032 SHALL cover: delta sequence +3,0,0,0 -> speed 0 (floor 3/4), 0, 0, 0; then -1 -> speed -1 (floor -1/4), dir=1.
REQ-033 SHALL cover: en dropped 5 cycles before a WE -> no speed_vld, speed=0, stall=0; re-enable -> PRIME window with no strobe before RUN.
REQ-034 SHALL cover: rst_n asserted mid-RUN -> all outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/coder_speed.sv
// coder_speed: windowed encoder speed measurement with 4-window averaging,
// direction flag and stall detection.
`default_nettype none

module coder_speed #(
    parameter int U_DLY     = 1,
    parameter int CLK_DIV   = 80,
    parameter int WIN_US    = 1000,
    parameter int STALL_WIN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] pco,
    output logic [15:0] speed,
    output logic        speed_vld,
    output logic        dir,
    output logic        stall
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WIN_W = (WIN_US > 1) ? $clog2(WIN_US) : 1;
    localparam int ZC_W  = $clog2(STALL_WIN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [WIN_W-1:0]   win_cnt;
    logic [15:0]        pos_prev;
    logic [3:0][15:0]   hist;
    logic [ZC_W-1:0]    zero_cnt, zc_nxt;
    logic               upd_pend;
    logic               tick, we;
    logic [17:0]        sum;
    logic [15:0]        avg;
    logic [1:0]         frac_unused;
    logic               dly_unused;

    assign dly_unused = (U_DLY != 0);

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign we   = tick && (win_cnt == WIN_W'(WIN_US - 1)) && (state != IDLE);

    // Sign-extended sum; dropping the two low bits is an arithmetic shift (floor).
    assign sum = {{2{hist[0][15]}}, hist[0]} + {{2{hist[1][15]}}, hist[1]}
               + {{2{hist[2][15]}}, hist[2]} + {{2{hist[3][15]}}, hist[3]};
    assign {avg, frac_unused} = sum;

    always_comb begin
        zc_nxt = '0;
        if (hist[0] == 16'd0) begin
            zc_nxt = (zero_cnt == ZC_W'(STALL_WIN)) ? zero_cnt : zero_cnt + ZC_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = PRIME;
            PRIME:   if (!en) state_nxt = IDLE; else if (we) state_nxt = RUN;
            RUN:     if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
        end else if (!en || state == IDLE) begin
            win_cnt <= '0;
        end else if (tick) begin
            win_cnt <= (win_cnt == WIN_W'(WIN_US - 1)) ? '0 : win_cnt + WIN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_prev  <= '0;
            hist      <= '0;
            zero_cnt  <= '0;
            upd_pend  <= 1'b0;
            speed     <= '0;
            speed_vld <= 1'b0;
            dir       <= 1'b0;
            stall     <= 1'b0;
        end else if (!en || state == IDLE) begin
            // Leaving IDLE always passes through here, so PRIME starts with empty history.
            hist      <= '0;
            zero_cnt  <= '0;
            upd_pend  <= 1'b0;
            speed     <= '0;
            speed_vld <= 1'b0;
            dir       <= 1'b0;
            stall     <= 1'b0;
        end else begin
            speed_vld <= 1'b0;
            upd_pend  <= 1'b0;
            if (we) begin
                pos_prev <= pco;
                if (state == RUN) begin
                    hist     <= {hist[2:0], pco - pos_prev};
                    upd_pend <= 1'b1;
                end
            end
            if (upd_pend) begin
                speed     <= avg;
                dir       <= avg[15];
                speed_vld <= 1'b1;
                zero_cnt  <= zc_nxt;
                stall     <= (zc_nxt == ZC_W'(STALL_WIN));
            end
        end
    end

endmodule

`default_nettype wire
